// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store unit between the CPU memory stage and a word-wide d_mem.
//   Byte/half/word requests become aligned 32-bit d_mem accesses. Loads are
//   lane-selected and sign/zero-extended. Word stores go straight through.
//   Sub-word stores take a read-modify-write over two cycles: a read cycle
//   with stall=1 that latches the merged word, then a write cycle.
//   Misaligned or illegal requests raise fault for that cycle only. A
//   saturating counter tracks completed sub-word stores.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   req_valid       a memory request is present this cycle
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    loads zero-extend when 1, sign-extend when 0
//   req_adr         byte address
//   req_wdata       store data, right-justified
//   rdata           extended load data
//   stall           CPU must hold its request while high
//   fault           misaligned/illegal request this cycle
//   rmw_count       completed sub-word stores, saturating
//   mem_adr         word-aligned d_mem address
//   mem_data_in     d_mem write data
//   mem_WrEn        d_mem write enable
//   mem_data_out    d_mem read data, valid before the next rising edge
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_adr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  fault,
  output logic [CNT_WIDTH-1:0]  rmw_count,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_WrEn,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [CNT_WIDTH-1:0]  rmw_count_q, rmw_count_d;

  logic [ADDR_WIDTH-1:0] adr_aligned;
  logic                  misaligned;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign adr_aligned = {req_adr[ADDR_WIDTH-1:2], 2'b00};

  assign misaligned = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_adr[0])
                    | ((req_size == 2'b10) & (req_adr[1:0] != 2'b00));

  // Lanes touched by a sub-word store.
  always_comb begin
    lane_en = 4'b0000;
    case (req_size)
      2'b00:   lane_en = 4'b0001 << req_adr[1:0];
      2'b01:   lane_en = req_adr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b0000;
    endcase
  end

  // Merged word: untouched lanes come from the read data; a byte store puts
  // wdata[7:0] in its lane, a half store puts wdata[15:8] in the odd lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = !lane_en[gi]          ? mem_data_out[8*gi +: 8] :
                                 (req_size == 2'b00)   ? req_wdata[7:0] :
                                                         req_wdata[8*(gi%2) +: 8];
    end
  endgenerate

  // Shift the addressed lane down to bit 0; aligned words shift by zero.
  assign ld_shift = mem_data_out >> {req_adr[1:0], 3'b000};

  always_comb begin
    case (req_size)
      2'b00:   ld_ext = {{(DATA_WIDTH-8){~req_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = {{(DATA_WIDTH-16){~req_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    rdata       = '0;
    stall       = 1'b0;
    fault       = 1'b0;
    mem_WrEn    = 1'b0;
    mem_adr     = adr_aligned;
    mem_data_in = '0;
    state_d     = state_q;
    adr_d       = adr_q;
    merge_d     = merge_q;
    rmw_count_d = rmw_count_q;

    if (rst) begin
      // Outputs quiet while in reset; a pending RMW write is dropped.
      mem_adr = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              fault = 1'b1;
            end else if (!req_we) begin
              rdata = ld_ext;
            end else if (req_size == 2'b10) begin
              mem_WrEn    = 1'b1;
              mem_data_in = req_wdata;
            end else begin
              // Read phase: d_mem returns the old word this cycle.
              stall   = 1'b1;
              merge_d = merged;
              adr_d   = adr_aligned;
              state_d = S_RMW_WR;
            end
          end
        end
        S_RMW_WR: begin
          mem_adr     = adr_q;
          mem_data_in = merge_q;
          mem_WrEn    = 1'b1;
          state_d     = S_IDLE;
          if (rmw_count_q != '1) begin
            rmw_count_d = rmw_count_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      merge_q     <= '0;
      rmw_count_q <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      merge_q     <= merge_d;
      rmw_count_q <= rmw_count_d;
    end
  end

  assign rmw_count = rmw_count_q;

endmodule
